// File: rtl/quad_imit_if.sv
// Purpose: bus between the motion generator (master) and one quadrature imitator (slave).
//  ena/step/dir        : master -> imitator strobes
//  A/B/Z               : imitated quadrature and index lines
//  pending             : signed count of steps not yet emitted
//  busy/overflow       : activity and sticky saturation flags
interface quad_imit_if #(
    parameter int unsigned PEND_W = 16
);
    logic                     ena;
    logic                     step;
    logic                     dir;
    logic                     A;
    logic                     B;
    logic                     Z;
    logic signed [PEND_W-1:0] pending;
    logic                     busy;
    logic                     overflow;

    modport master (
        output ena, step, dir,
        input  A, B, Z, pending, busy, overflow
    );

    modport slave (
        input  ena, step, dir,
        output A, B, Z, pending, busy, overflow
    );
endinterface

// File: rtl/quad_imit.sv
// Purpose: quadrature encoder imitator. Converts step/dir strobes into A/B/Z edges spaced
// at least MIN_PHASE clocks apart, buffering unemitted steps in a saturating signed count.
// Ports:
//  clk   : system clock
//  sclr  : synchronous active-high reset
//  clr   : synchronous clear from the encoder bus, same effect as sclr
//  bus   : quad_imit_if.slave (ena/step/dir in; A/B/Z/pending/busy/overflow out, all registered)
module quad_imit #(
    parameter int unsigned MIN_PHASE = 4,
    parameter int unsigned PEND_W    = 16,
    parameter int unsigned Z_PERIOD  = 4000
) (
    input  logic       clk,
    input  logic       sclr,
    input  logic       clr,
    quad_imit_if.slave bus
);
    localparam int unsigned POS_W = $clog2(Z_PERIOD);
    localparam int unsigned TMR_W = (MIN_PHASE > 1) ? $clog2(MIN_PHASE) : 1;
    localparam int unsigned SUM_W = PEND_W + 2;

    localparam logic [POS_W-1:0]        POS_LAST = POS_W'(Z_PERIOD - 1);
    localparam logic [TMR_W-1:0]        TMR_LOAD = TMR_W'(MIN_PHASE - 1);
    localparam logic signed [SUM_W-1:0] PEND_LIM = $signed({3'b000, {(PEND_W-1){1'b1}}});
    localparam logic signed [SUM_W-1:0] P_ONE    = $signed(SUM_W'(1));
    localparam logic signed [SUM_W-1:0] M_ONE    = $signed({SUM_W{1'b1}});

    logic signed [PEND_W-1:0] pend_q, pend_d;
    logic [POS_W-1:0]         pos_q, pos_d;
    logic [TMR_W-1:0]         tmr_q, tmr_d;
    logic                     ovf_q, ovf_d;
    logic                     a_q, a_d;
    logic                     b_q, b_d;
    logic                     z_q, z_d;
    logic                     busy_q, busy_d;

    logic                     emit;
    logic signed [SUM_W-1:0]  pend_ext;
    logic signed [SUM_W-1:0]  step_dl;
    logic signed [SUM_W-1:0]  emit_dl;
    logic signed [SUM_W-1:0]  sum_raw;
    logic signed [SUM_W-1:0]  sum_sat;

    // State register; clr and sclr both win over any same-cycle step.
    always_ff @(posedge clk) begin
        if (sclr || clr) begin
            pend_q <= '0;
            pos_q  <= '0;
            tmr_q  <= '0;
            ovf_q  <= 1'b0;
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            z_q    <= 1'b1;
            busy_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            pos_q  <= pos_d;
            tmr_q  <= tmr_d;
            ovf_q  <= ovf_d;
            a_q    <= a_d;
            b_q    <= b_d;
            z_q    <= z_d;
            busy_q <= busy_d;
        end
    end

    // Next state: accumulate, emit one edge when allowed, derive outputs from the new position.
    always_comb begin
        pend_d   = pend_q;
        pos_d    = pos_q;
        tmr_d    = tmr_q;
        ovf_d    = ovf_q;
        step_dl  = '0;
        emit_dl  = '0;

        emit     = bus.ena && (tmr_q == '0) && (pend_q != '0);
        pend_ext = $signed({{2{pend_q[PEND_W-1]}}, pend_q});

        if (bus.step) begin
            step_dl = bus.dir ? M_ONE : P_ONE;
        end
        if (emit) begin
            emit_dl = pend_q[PEND_W-1] ? M_ONE : P_ONE;
        end

        // An emitted edge always moves pending toward zero, so only the step can overshoot.
        sum_raw = pend_ext + step_dl - emit_dl;
        sum_sat = sum_raw;
        if ((sum_raw > PEND_LIM) || (sum_raw < -PEND_LIM)) begin
            sum_sat = pend_ext - emit_dl;
            ovf_d   = 1'b1;
        end
        pend_d = sum_sat[PEND_W-1:0];

        if (emit) begin
            tmr_d = TMR_LOAD;
            if (!pend_q[PEND_W-1]) begin
                pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
            end else begin
                pos_d = (pos_q == '0) ? POS_LAST : pos_q - POS_W'(1);
            end
        end else if (tmr_q != '0) begin
            tmr_d = tmr_q - TMR_W'(1);
        end

        // Quadrature phase is pos[1:0]; Z_PERIOD is a multiple of 4 so the wrap keeps them aligned.
        a_d    = pos_d[1] ^ pos_d[0];
        b_d    = pos_d[1];
        z_d    = (pos_d == '0);
        busy_d = (pend_d != '0) || (tmr_d != '0);
    end

    assign bus.A        = a_q;
    assign bus.B        = b_q;
    assign bus.Z        = z_q;
    assign bus.pending  = pend_q;
    assign bus.busy     = busy_q;
    assign bus.overflow = ovf_q;
endmodule
